mux_rr_arbiter: RTL

Round-robin arbiter that shares the team's CHANNELS-to-1 WIDTH-bit multiplexer among CHANNELS valid/ready requesters and drives one registered output stream. It selects a channel, generates the mux select, and captures the selected word into an output register. It also holds a grant across a multi-word packet, delimited by a per-channel last flag. It sits between independent producers and a single shared downstream consumer.

---
 rtl/mux_rr_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter in front of a shared CHANNELS-to-1 mux.
// It grants one valid/ready requester at a time and captures the granted word
// into a single registered output stage. A grant is held across a multi-word
// packet until the word flagged by in_last is accepted.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_bus               packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid, in_last    per-channel request and end-of-packet flag
//   in_ready             per-channel accept, one-hot or zero
//   out_data, out_chan   registered word and its source channel
//   out_last, out_valid  registered end-of-packet flag and word-present flag
//   out_ready            downstream accept
//   sel                  combinational grant index, drives the shared mux select
`timescale 1ns / 1ps

module mux_rr_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          sel
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    localparam int unsigned CW = SEL_W + 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic [SEL_W-1:0]   r_lock, w_lock_nxt;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_chan;
    logic               r_out_last;
    logic               r_out_valid;

    logic [CW-1:0]       w_cand;
    logic                w_found;
    logic [SEL_W-1:0]    w_idle_grant;
    logic [SEL_W-1:0]    w_grant;
    logic                w_slot_free;
    logic                w_accept;
    logic                w_grant_last;
    logic [WIDTH-1:0]    w_grant_data;
    logic [CHANNELS-1:0] w_in_ready;

    // Increment modulo CHANNELS (not modulo 2^SEL_W).
    function automatic logic [SEL_W-1:0] f_inc(input logic [SEL_W-1:0] c);
        return (c == SEL_W'(CHANNELS - 1)) ? '0 : c + SEL_W'(1);
    endfunction

    // First requester in order ptr, ptr+1, ... wrapping at CHANNELS.
    always_comb begin
        w_found      = 1'b0;
        w_idle_grant = r_ptr;
        w_cand       = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_cand = {1'b0, r_ptr} + CW'(i);
            if (w_cand >= CW'(CHANNELS)) begin
                w_cand = w_cand - CW'(CHANNELS);
            end
            if (!w_found && in_valid[w_cand[SEL_W-1:0]]) begin
                w_found      = 1'b1;
                w_idle_grant = w_cand[SEL_W-1:0];
            end
        end
    end

    assign w_grant      = (r_state == StLocked) ? r_lock : w_idle_grant;
    assign w_slot_free  = !r_out_valid || out_ready;
    // rst_n gating keeps in_ready low while reset is held.
    assign w_accept     = rst_n && w_slot_free && in_valid[w_grant];
    assign w_grant_last = in_last[w_grant];
    assign w_grant_data = in_bus[32'(w_grant) * WIDTH +: WIDTH];

    always_comb begin
        w_in_ready = '0;
        if (w_accept) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        if (w_accept) begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_last) begin
                        w_ptr_nxt = f_inc(w_grant);
                    end else begin
                        w_lock_nxt  = w_grant;
                        w_state_nxt = StLocked;
                    end
                end
                StLocked: begin
                    if (w_grant_last) begin
                        w_ptr_nxt   = f_inc(r_lock);
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_lock  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    // Output stage: reload on accept, empty when free and idle, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_grant_data;
            r_out_chan  <= w_grant;
            r_out_last  <= w_grant_last;
            r_out_valid <= 1'b1;
        end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign sel       = w_grant;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule
